// File: rtl/bus_pkg.sv
// Shared types for the two-requester register-bus arbiter.
// Holds the FSM state enum, the pending-request payload struct and the
// round-robin pick helper used by rr_arbiter.
package bus_pkg;

  // Payload fields are sized for the widest supported bus; users narrow them with casts.
  localparam int unsigned BUS_ADDR_MAX = 32;
  localparam int unsigned BUS_DATA_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [BUS_ADDR_MAX-1:0] addr;
    logic [BUS_DATA_MAX-1:0] wdata;
    logic                    rw;
  } bus_req_t;

  // 2-way round robin: on a tie the last-granted requester loses.
  function automatic logic rr_pick(input logic [1:0] pending, input logic last);
    logic pick;
    pick = 1'b0;
    if (&pending) begin
      pick = ~last;
    end else if (pending[1]) begin
      pick = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational 2-way round-robin grant.
// Ports: pending_i - per-requester pending bits
//        last_i    - index of the last-granted requester
//        gnt_idx_c - index of the winner (valid when gnt_any_c)
//        gnt_any_c - at least one requester pending
module rr_arbiter
  import bus_pkg::*;
(
  input  logic [1:0] pending_i,
  input  logic       last_i,
  output logic       gnt_idx_c,
  output logic       gnt_any_c
);

  always_comb begin
    gnt_any_c = |pending_i;
    gnt_idx_c = rr_pick(pending_i, last_i);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester arbiter in front of a daisy-chained register bus.
// Each requester owns a one-deep pending slot; one transaction is outstanding
// at a time (IDLE -> ISSUE -> WAIT), granted round-robin.
// Optional feature macro: ARB_TIMEOUT_EN adds a WAIT timeout counter and req_err_o.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   req_addr_i/req_wdata_i       - per-requester address / write data (requester i in slice i)
//   req_rw_i/req_valid_i         - per-requester access type (1=write) / request strobe
//   req_rdata_o/req_valid_o      - per-requester response data / response strobe
//   req_err_o                    - per-requester timeout flag (ARB_TIMEOUT_EN only)
//   addr_o/wdata_o/rw_o/valid_o  - request to bus head
//   rdata_i/valid_i              - response from bus tail
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]              req_rw_i,
  input  logic [1:0]              req_valid_i,
  output logic [2*DATA_WIDTH-1:0] req_rdata_o,
  output logic [1:0]              req_valid_o,
`ifdef ARB_TIMEOUT_EN
  output logic [1:0]              req_err_o,
`endif
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic                    rw_o,
  output logic                    valid_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i,
  input  logic                    valid_i
);

  arb_state_e state_q, state_d;
  bus_req_t   slot_q [2];
  bus_req_t   slot_d [2];
  logic [1:0] pend_q, pend_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];
  logic [1:0]            rsp_valid_q, rsp_valid_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
`endif

  logic [1:0] clr_c;
  logic       gnt_idx_c;
  logic       gnt_any_c;

  rr_arbiter u_rr (
    .pending_i (pend_q),
    .last_i    (last_q),
    .gnt_idx_c (gnt_idx_c),
    .gnt_any_c (gnt_any_c)
  );

  // Next-state, bus drive, response and slot bookkeeping
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    pend_d      = pend_q;
    grant_d     = grant_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = 1'b0;
    valid_d     = 1'b0;
    rdata_d     = rdata_q;
    rsp_valid_d = 2'b00;
    clr_c       = 2'b00;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 2'b00;
`endif

    case (state_q)
      ST_IDLE: begin
        // Bus outputs are loaded here so valid_o is high exactly while in ISSUE.
        if (gnt_any_c) begin
          grant_d = gnt_idx_c;
          last_d  = gnt_idx_c;
          addr_d  = ADDR_WIDTH'(slot_q[gnt_idx_c].addr);
          wdata_d = DATA_WIDTH'(slot_q[gnt_idx_c].wdata);
          rw_d    = slot_q[gnt_idx_c].rw;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (valid_i) begin
          rdata_d[grant_q]     = rdata_i;
          rsp_valid_d[grant_q] = 1'b1;
          clr_c[grant_q]       = 1'b1;
          state_d              = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d[grant_q]     = '0;
          rsp_valid_d[grant_q] = 1'b1;
          err_d[grant_q]       = 1'b1;
          clr_c[grant_q]       = 1'b1;
          state_d              = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear first so a request landing on the freeing cycle is captured.
    for (int i = 0; i < 2; i++) begin
      if (clr_c[i]) begin
        pend_d[i] = 1'b0;
      end
      if (req_valid_i[i] && !pend_d[i]) begin
        pend_d[i]       = 1'b1;
        slot_d[i].addr  = BUS_ADDR_MAX'(req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
        slot_d[i].wdata = BUS_DATA_MAX'(req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH]);
        slot_d[i].rw    = req_rw_i[i];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      slot_q[0]   <= '0;
      slot_q[1]   <= '0;
      pend_q      <= 2'b00;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      valid_q     <= 1'b0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
      rsp_valid_q <= 2'b00;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pend_q      <= pend_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req_rdata_o = {rdata_q[1], rdata_q[0]};
  assign req_valid_o = rsp_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign req_err_o   = err_q;
`endif
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign rw_o        = rw_q;
  assign valid_o     = valid_q;

endmodule
